// File: rtl/riscv_uart_loader.sv
// UART program loader: receives an A5/LEN/data/CSUM frame, writes little-endian words
// to instruction memory and holds the CPU until the checksum passes. Optional: RISCV_LOADER_TIMEOUT_EN.
module riscv_uart_loader #(
   parameter int CLK_FREQ     = 23000000,
   parameter int BAUD         = 115200,
   parameter int ADDR_WIDTH   = 14,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  uart_rx,
   input  logic                  load_req,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam int CNT_W    = $clog2(BAUD_DIV + 1);
   localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, WAIT_HDR, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

   rx_state_t        rx_state_reg;
   logic             rx_s1_reg, rx_s2_reg, rx_prev_reg;
   logic [CNT_W-1:0] baud_cnt_reg;
   logic [2:0]       bit_cnt_reg;
   logic [7:0]       shift_reg;
   logic [7:0]       rx_byte_reg;
   logic             rx_valid_reg, rx_ferr_reg;

   // 8N1 receiver: start bit checked at mid-bit, data/stop sampled every BAUD_DIV thereafter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_reg <= RX_IDLE;
         rx_s1_reg    <= 1'b1;
         rx_s2_reg    <= 1'b1;
         rx_prev_reg  <= 1'b1;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         rx_byte_reg  <= '0;
         rx_valid_reg <= 1'b0;
         rx_ferr_reg  <= 1'b0;
      end else begin
         rx_s1_reg    <= uart_rx;
         rx_s2_reg    <= rx_s1_reg;
         rx_prev_reg  <= rx_s2_reg;
         rx_valid_reg <= 1'b0;
         rx_ferr_reg  <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               if (rx_prev_reg && !rx_s2_reg) begin
                  rx_state_reg <= RX_START;
                  baud_cnt_reg <= '0;
               end
            end
            RX_START: begin
               if (baud_cnt_reg == CNT_W'(HALF_DIV - 1)) begin
                  baud_cnt_reg <= '0;
                  bit_cnt_reg  <= '0;
                  rx_state_reg <= rx_s2_reg ? RX_IDLE : RX_DATA;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
            RX_DATA: begin
               if (baud_cnt_reg == CNT_W'(BAUD_DIV - 1)) begin
                  baud_cnt_reg <= '0;
                  shift_reg    <= {rx_s2_reg, shift_reg[7:1]};
                  bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == 3'd7) rx_state_reg <= RX_STOP;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
            RX_STOP: begin
               if (baud_cnt_reg == CNT_W'(BAUD_DIV - 1)) begin
                  baud_cnt_reg <= '0;
                  rx_state_reg <= RX_IDLE;
                  if (rx_s2_reg) begin
                     rx_valid_reg <= 1'b1;
                     rx_byte_reg  <= shift_reg;
                  end else begin
                     rx_ferr_reg  <= 1'b1;
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
            default: rx_state_reg <= RX_IDLE;
         endcase
      end
   end

   state_t                state_reg, state_next;
   logic [7:0]            len_lo_reg;
   logic [15:0]           len_reg;
   logic [ADDR_WIDTH:0]   index_reg;
   logic [1:0]            byte_cnt_reg;
   logic [7:0]            csum_reg;
   logic [23:0]           word_reg;
   logic                  start, in_frame, last_word, timeout;
   logic [15:0]           len_rx;

   assign start     = load_req && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);
   assign in_frame  = (state_reg == LEN_LO) || (state_reg == LEN_HI) || (state_reg == DATA) || (state_reg == CSUM);
   assign len_rx    = {rx_byte_reg, len_lo_reg};
   assign last_word = (33'(index_reg) + 33'd1) == 33'(len_reg);

`ifdef RISCV_LOADER_TIMEOUT_EN
   localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);
   logic [TO_W-1:0] to_cnt_reg;

   // saturating idle counter; WAIT_HDR is excluded so a loader can sit armed forever
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       to_cnt_reg <= '0;
      else if (rx_valid_reg || start) to_cnt_reg <= '0;
      else if (to_cnt_reg != TO_W'(TO_LIMIT)) to_cnt_reg <= to_cnt_reg + 1'b1;
   end

   assign timeout = in_frame && (to_cnt_reg == TO_W'(TO_LIMIT));
`else
   // no timeout in this build; TIMEOUT_BITS stays on the interface for the timeout build
   assign timeout = (TIMEOUT_BITS < 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE, ERR: if (load_req) state_next = WAIT_HDR;
         WAIT_HDR: if (rx_valid_reg && rx_byte_reg == 8'hA5) state_next = LEN_LO;
         LEN_LO:   if (rx_valid_reg) state_next = LEN_HI;
         LEN_HI: begin
            if (rx_valid_reg) begin
               if (33'(len_rx) > MAX_WORDS) state_next = ERR;
               else if (len_rx == 16'd0)    state_next = CSUM;
               else                         state_next = DATA;
            end
         end
         DATA: if (rx_valid_reg && byte_cnt_reg == 2'd3 && last_word) state_next = CSUM;
         CSUM: if (rx_valid_reg) state_next = (rx_byte_reg == csum_reg) ? DONE : ERR;
         default: state_next = IDLE;
      endcase
      if ((state_reg == WAIT_HDR || in_frame) && (rx_ferr_reg || timeout)) state_next = ERR;
   end

   always_comb begin
      busy     = (state_reg == WAIT_HDR) || in_frame;
      cpu_hold = busy || (state_reg == ERR);
      done     = (state_reg == DONE);
      error    = (state_reg == ERR);
   end

   // word assembly; the write strobe lands the cycle after the 4th byte of a word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_lo_reg   <= '0;
         len_reg      <= '0;
         index_reg    <= '0;
         byte_cnt_reg <= '0;
         csum_reg     <= '0;
         word_reg     <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
      end else begin
         imem_we <= 1'b0;
         if (start) begin
            index_reg    <= '0;
            csum_reg     <= '0;
            byte_cnt_reg <= '0;
         end else if (rx_valid_reg) begin
            case (state_reg)
               LEN_LO: len_lo_reg <= rx_byte_reg;
               LEN_HI: len_reg    <= len_rx;
               DATA: begin
                  csum_reg     <= csum_reg ^ rx_byte_reg;
                  byte_cnt_reg <= byte_cnt_reg + 1'b1;
                  case (byte_cnt_reg)
                     2'd0: word_reg[7:0]   <= rx_byte_reg;
                     2'd1: word_reg[15:8]  <= rx_byte_reg;
                     2'd2: word_reg[23:16] <= rx_byte_reg;
                     default: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= index_reg[ADDR_WIDTH-1:0];
                        imem_wdata <= {rx_byte_reg, word_reg};
                        index_reg  <= index_reg + 1'b1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_riscv_uart_loader.sv
// Self-checking bench for riscv_uart_loader: table of known frames, hand-written corner
// sequences and random frames checked against a frame-level reference model.
module tb_riscv_uart_loader;

   localparam int AW   = 4;
   localparam int DIV  = 16;
   localparam int MAXW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          uart_rx = 1'b1;
   logic          load_req = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold, busy, done, error;

   riscv_uart_loader #(
      .CLK_FREQ(1600), .BAUD(100), .ADDR_WIDTH(AW), .TIMEOUT_BITS(20)
   ) dut (
      .clk(clk), .rst(rst), .uart_rx(uart_rx), .load_req(load_req),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [35:0] wr_q[$];   // observed writes {addr, data}
   logic [35:0] e_wr[$];   // expected writes
   logic [7:0]  m_in[$];   // bytes of the frame being sent
   bit          e_done, e_err;

   always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (DIV) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_load();
      @(negedge clk) load_req = 1'b1;
      @(negedge clk) load_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Frame-level reference: find header, read length, split data into LE words, XOR checksum.
   task automatic model_run();
      int i;
      int len;
      logic [7:0] cs;
      e_wr.delete();
      e_done = 1'b0;
      e_err  = 1'b0;
      i = 0;
      while (i < m_in.size() && m_in[i] != 8'hA5) i++;
      if (i + 3 > m_in.size()) return;
      len = int'({m_in[i+2], m_in[i+1]});
      i += 3;
      if (len > MAXW) begin
         e_err = 1'b1;
         return;
      end
      cs = 8'h00;
      for (int w = 0; w < len; w++) begin
         if (i + 4 > m_in.size()) return;
         cs = cs ^ m_in[i] ^ m_in[i+1] ^ m_in[i+2] ^ m_in[i+3];
         e_wr.push_back({4'(w), m_in[i+3], m_in[i+2], m_in[i+1], m_in[i]});
         i += 4;
      end
      if (i >= m_in.size()) return;
      if (m_in[i] == cs) e_done = 1'b1;
      else               e_err  = 1'b1;
   endtask

   task automatic compare_result(input string tag);
      int n;
      check($sformatf("%s nwrites", tag), 64'(wr_q.size()), 64'(e_wr.size()));
      n = (wr_q.size() < e_wr.size()) ? wr_q.size() : e_wr.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s write%0d", tag, i), 64'(wr_q[i]), 64'(e_wr[i]));
      check($sformatf("%s done", tag), 64'(done), 64'(e_done));
      check($sformatf("%s error", tag), 64'(error), 64'(e_err));
      check($sformatf("%s busy", tag), 64'(busy), 64'(!(e_done || e_err)));
      check($sformatf("%s cpu_hold", tag), 64'(cpu_hold), 64'(!e_done));
   endtask

   task automatic do_frame(input string tag);
      wr_q.delete();
      pulse_load();
      foreach (m_in[k]) send_byte(m_in[k], 1'b1);
      repeat (20) @(negedge clk);
      compare_result(tag);
   endtask

   task automatic check_zero(input string tag);
      check($sformatf("%s imem_we", tag), 64'(imem_we), 64'd0);
      check($sformatf("%s imem_addr", tag), 64'(imem_addr), 64'd0);
      check($sformatf("%s imem_wdata", tag), 64'(imem_wdata), 64'd0);
      check($sformatf("%s cpu_hold", tag), 64'(cpu_hold), 64'd0);
      check($sformatf("%s busy", tag), 64'(busy), 64'd0);
      check($sformatf("%s done", tag), 64'(done), 64'd0);
      check($sformatf("%s error", tag), 64'(error), 64'd0);
   endtask

   typedef struct {
      int          n;
      logic [7:0]  b [0:11];
      int          nw;
      logic [35:0] w [0:1];
      bit          d;
      bit          e;
   } vec_t;

   vec_t tbl [0:5];

   initial begin
      // XOR of 13 05 10 00 B7 02 00 00 is 0xB3
      tbl[0].n = 12; tbl[0].b = '{8'hA5,8'h02,8'h00,8'h13,8'h05,8'h10,8'h00,8'hB7,8'h02,8'h00,8'h00,8'hB3};
      tbl[0].nw = 2; tbl[0].w = '{36'h0_00100513, 36'h1_000002B7}; tbl[0].d = 1; tbl[0].e = 0;
      tbl[1].n = 12; tbl[1].b = '{8'hA5,8'h02,8'h00,8'h13,8'h05,8'h10,8'h00,8'hB7,8'h02,8'h00,8'h00,8'h00};
      tbl[1].nw = 2; tbl[1].w = '{36'h0_00100513, 36'h1_000002B7}; tbl[1].d = 0; tbl[1].e = 1;
      tbl[2].n = 10; tbl[2].b = '{8'h00,8'hFF,8'hA5,8'h01,8'h00,8'hDE,8'hAD,8'hBE,8'hEF,8'h22,8'h00,8'h00};
      tbl[2].nw = 1; tbl[2].w = '{36'h0_EFBEADDE, 36'h0}; tbl[2].d = 1; tbl[2].e = 0;
      tbl[3].n = 3;  tbl[3].b = '{8'hA5,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      tbl[3].nw = 0; tbl[3].w = '{36'h0, 36'h0}; tbl[3].d = 0; tbl[3].e = 1;
      tbl[4].n = 4;  tbl[4].b = '{8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      tbl[4].nw = 0; tbl[4].w = '{36'h0, 36'h0}; tbl[4].d = 1; tbl[4].e = 0;
      tbl[5].n = 4;  tbl[5].b = '{8'hA5,8'h00,8'h00,8'h5A,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      tbl[5].nw = 0; tbl[5].w = '{36'h0, 36'h0}; tbl[5].d = 0; tbl[5].e = 1;

      repeat (4) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;
      repeat (4) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         m_in.delete();
         e_wr.delete();
         for (int k = 0; k < tbl[v].n; k++) m_in.push_back(tbl[v].b[k]);
         for (int k = 0; k < tbl[v].nw; k++) e_wr.push_back(tbl[v].w[k]);
         e_done = tbl[v].d;
         e_err  = tbl[v].e;
         do_frame($sformatf("vec%0d", v));
      end

      // load_req while busy must not restart the load
      wr_q.delete();
      pulse_load();
      send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      pulse_load();
      send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
      send_byte(8'h44, 1'b1);
      repeat (20) @(negedge clk);
      e_wr.delete(); e_wr.push_back(36'h0_44332211);
      e_done = 1'b1; e_err = 1'b0;
      compare_result("busy_req");

      // maximum image: 2**ADDR_WIDTH words
      m_in.delete();
      m_in.push_back(8'hA5); m_in.push_back(8'(MAXW)); m_in.push_back(8'h00);
      for (int k = 0; k < 4 * MAXW; k++) m_in.push_back(8'($urandom));
      begin
         logic [7:0] cs = 8'h00;
         for (int k = 3; k < m_in.size(); k++) cs ^= m_in[k];
         m_in.push_back(cs);
      end
      model_run();
      do_frame("maxlen");

      // framing error inside the data phase
      wr_q.delete();
      pulse_load();
      send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'hDE, 1'b0);
      repeat (20) @(negedge clk);
      e_wr.delete(); e_done = 1'b0; e_err = 1'b1;
      compare_result("ferr");

      // random frames against the reference model
      for (int r = 0; r < 8; r++) begin
         int len;
         logic [7:0] cs;
         m_in.delete();
         repeat ($urandom_range(0, 2)) m_in.push_back(8'($urandom_range(0, 8'hA4)));
         len = ($urandom_range(0, 4) == 0) ? $urandom_range(MAXW + 1, MAXW + 2) : $urandom_range(0, 4);
         m_in.push_back(8'hA5); m_in.push_back(8'(len)); m_in.push_back(8'h00);
         cs = 8'h00;
         for (int k = 0; k < 4 * ((len > MAXW) ? 1 : len); k++) begin
            m_in.push_back(8'($urandom));
            cs ^= m_in[m_in.size() - 1];
         end
         if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
         m_in.push_back(cs);
         m_in.push_back(8'($urandom));
         model_run();
         do_frame($sformatf("rand%0d", r));
      end

      // asynchronous reset in the middle of a word
      wr_q.delete();
      pulse_load();
      send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
      check("midreset nwrites_before", 64'(wr_q.size()), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero("midreset");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      m_in.delete();
      m_in = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      e_wr.delete(); e_wr.push_back(36'h0_12345678);
      e_done = 1'b1; e_err = 1'b0;
      do_frame("after_reset");

      // silence after the length low byte
      wr_q.delete();
      pulse_load();
      send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
      repeat (400) @(negedge clk);
`ifdef RISCV_LOADER_TIMEOUT_EN
      check("timeout error", 64'(error), 64'd1);
      check("timeout busy", 64'(busy), 64'd0);
`else
      check("timeout error", 64'(error), 64'd0);
      check("timeout busy", 64'(busy), 64'd1);
`endif
      check("timeout cpu_hold", 64'(cpu_hold), 64'd1);
      check("timeout nwrites", 64'(wr_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
